// File: rtl/axi_mem_arb_pkg.sv
// Types and the fairness-update helper used by the read/write bank arbiter.
package axi_mem_arb_pkg;

  localparam int unsigned AtopWidth = 6;

  typedef logic [AtopWidth-1:0] atop_t;

  typedef enum logic {
    SelRead  = 1'b0,
    SelWrite = 1'b1
  } port_sel_e;

  // A contended handshake hands priority to the port that just lost.
  function automatic port_sel_e prio_update(input port_sel_e prio,
                                            input port_sel_e sel,
                                            input logic      handshake,
                                            input logic      contended);
    if (handshake && contended) begin
      return (sel == SelRead) ? SelWrite : SelRead;
    end
    return prio;
  endfunction

endpackage

// File: rtl/axi_mem_rw_bank_arb_slice.sv
// One bank: read/write selection with lock and fairness, plus the owner queue
// that steers each in-order memory response back to its requester.
module axi_mem_rw_bank_arb_slice
  import axi_mem_arb_pkg::*;
#(
  parameter int unsigned AddrWidth      = 32,
  parameter int unsigned MemDataWidth   = 32,
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      rd_req_i,
  input  logic                      wr_req_i,
  output logic                      rd_gnt_o,
  output logic                      wr_gnt_o,
  input  logic [AddrWidth-1:0]      rd_addr_i,
  input  logic [AddrWidth-1:0]      wr_addr_i,
  input  logic [MemDataWidth-1:0]   rd_wdata_i,
  input  logic [MemDataWidth-1:0]   wr_wdata_i,
  input  logic [MemDataWidth/8-1:0] rd_strb_i,
  input  logic [MemDataWidth/8-1:0] wr_strb_i,
  input  atop_t                     rd_atop_i,
  input  atop_t                     wr_atop_i,
  input  logic                      rd_we_i,
  input  logic                      wr_we_i,
  output logic                      rd_rvalid_o,
  output logic                      wr_rvalid_o,
  output logic [MemDataWidth-1:0]   rd_rdata_o,
  output logic [MemDataWidth-1:0]   wr_rdata_o,
  output logic                      mem_req_o,
  input  logic                      mem_gnt_i,
  output logic [AddrWidth-1:0]      mem_addr_o,
  output logic [MemDataWidth-1:0]   mem_wdata_o,
  output logic [MemDataWidth/8-1:0] mem_strb_o,
  output atop_t                     mem_atop_o,
  output logic                      mem_we_o,
  input  logic                      mem_rvalid_i,
  input  logic [MemDataWidth-1:0]   mem_rdata_i,
  output logic                      busy_o
);

  localparam int unsigned PtrWidth = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int unsigned CntWidth = $clog2(MaxOutstanding + 1);

  port_sel_e                prio_q, lock_sel_q, sel, head;
  logic                     lock_q, sel_req, handshake, contended;
  logic                     push, pop, full, empty;
  logic [MaxOutstanding-1:0] owner_q;
  logic [PtrWidth-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CntWidth-1:0]      cnt_q;

  function automatic logic [PtrWidth-1:0] ptr_next(input logic [PtrWidth-1:0] ptr);
    return (ptr == PtrWidth'(MaxOutstanding - 1)) ? '0 : ptr + PtrWidth'(1);
  endfunction

  // A locked selection wins; otherwise a lone requester, otherwise priority.
  always_comb begin
    sel = SelRead;
    if (lock_q) begin
      sel = lock_sel_q;
    end else if (rd_req_i && wr_req_i) begin
      sel = prio_q;
    end else if (wr_req_i) begin
      sel = SelWrite;
    end
  end

  assign contended = rd_req_i & wr_req_i;
  assign sel_req   = (sel == SelWrite) ? wr_req_i : rd_req_i;
  assign full      = (cnt_q == CntWidth'(MaxOutstanding));
  assign empty     = (cnt_q == '0);
  assign mem_req_o = sel_req & ~full & ~rst_i;
  assign handshake = mem_req_o & mem_gnt_i;
  assign rd_gnt_o  = handshake & (sel == SelRead);
  assign wr_gnt_o  = handshake & (sel == SelWrite);

  assign mem_addr_o  = (sel == SelWrite) ? wr_addr_i  : rd_addr_i;
  assign mem_wdata_o = (sel == SelWrite) ? wr_wdata_i : rd_wdata_i;
  assign mem_strb_o  = (sel == SelWrite) ? wr_strb_i  : rd_strb_i;
  assign mem_atop_o  = (sel == SelWrite) ? wr_atop_i  : rd_atop_i;
  assign mem_we_o    = (sel == SelWrite) ? wr_we_i    : rd_we_i;

  // Responses with nothing outstanding are dropped.
  assign push        = handshake;
  assign pop         = mem_rvalid_i & ~empty;
  assign head        = port_sel_e'(owner_q[rd_ptr_q]);
  assign rd_rvalid_o = pop & ~rst_i & (head == SelRead);
  assign wr_rvalid_o = pop & ~rst_i & (head == SelWrite);
  assign rd_rdata_o  = mem_rdata_i;
  assign wr_rdata_o  = mem_rdata_i;

  assign busy_o = ~empty | rd_req_i | wr_req_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      prio_q     <= SelRead;
      lock_q     <= 1'b0;
      lock_sel_q <= SelRead;
    end else begin
      prio_q <= prio_update(prio_q, sel, handshake, contended);
      lock_q <= mem_req_o & ~mem_gnt_i;
      if (mem_req_o && !mem_gnt_i) begin
        lock_sel_q <= sel;
      end
    end
  end

  // Owner queue: registered occupancy, so a pop never unblocks the same cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      owner_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) begin
        owner_q[wr_ptr_q] <= sel;
        wr_ptr_q          <= ptr_next(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_q <= ptr_next(rd_ptr_q);
      end
      unique case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CntWidth'(1);
        2'b01:   cnt_q <= cnt_q - CntWidth'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  a_lock_held: assert property (@(posedge clk_i) disable iff (rst_i)
    lock_q |-> ((lock_sel_q == SelWrite) ? wr_req_i : rd_req_i))
    else $error("locked requester withdrew its request");

  a_rvalid_owned: assert property (@(posedge clk_i) disable iff (rst_i)
    mem_rvalid_i |-> !empty)
    else $warning("memory response with nothing outstanding was dropped");

endmodule

// File: rtl/axi_mem_rw_bank_arbiter.sv
// Per-bank read/write arbitration onto single-ported SRAM banks; banks are
// independent slices and only the busy indication is shared.
module axi_mem_rw_bank_arbiter
  import axi_mem_arb_pkg::*;
#(
  parameter int unsigned NumBanks       = 2,
  parameter int unsigned AddrWidth      = 32,
  parameter int unsigned MemDataWidth   = 32,
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  output logic                                busy_o,
  input  logic [NumBanks-1:0]                 rd_req_i,
  input  logic [NumBanks-1:0]                 wr_req_i,
  output logic [NumBanks-1:0]                 rd_gnt_o,
  output logic [NumBanks-1:0]                 wr_gnt_o,
  input  logic [NumBanks*AddrWidth-1:0]       rd_addr_i,
  input  logic [NumBanks*AddrWidth-1:0]       wr_addr_i,
  input  logic [NumBanks*MemDataWidth-1:0]    rd_wdata_i,
  input  logic [NumBanks*MemDataWidth-1:0]    wr_wdata_i,
  input  logic [NumBanks*MemDataWidth/8-1:0]  rd_strb_i,
  input  logic [NumBanks*MemDataWidth/8-1:0]  wr_strb_i,
  input  logic [NumBanks*AtopWidth-1:0]       rd_atop_i,
  input  logic [NumBanks*AtopWidth-1:0]       wr_atop_i,
  input  logic [NumBanks-1:0]                 rd_we_i,
  input  logic [NumBanks-1:0]                 wr_we_i,
  output logic [NumBanks-1:0]                 rd_rvalid_o,
  output logic [NumBanks-1:0]                 wr_rvalid_o,
  output logic [NumBanks*MemDataWidth-1:0]    rd_rdata_o,
  output logic [NumBanks*MemDataWidth-1:0]    wr_rdata_o,
  output logic [NumBanks-1:0]                 mem_req_o,
  input  logic [NumBanks-1:0]                 mem_gnt_i,
  output logic [NumBanks*AddrWidth-1:0]       mem_addr_o,
  output logic [NumBanks*MemDataWidth-1:0]    mem_wdata_o,
  output logic [NumBanks*MemDataWidth/8-1:0]  mem_strb_o,
  output logic [NumBanks*AtopWidth-1:0]       mem_atop_o,
  output logic [NumBanks-1:0]                 mem_we_o,
  input  logic [NumBanks-1:0]                 mem_rvalid_i,
  input  logic [NumBanks*MemDataWidth-1:0]    mem_rdata_i
);

  localparam int unsigned StrbWidth = MemDataWidth / 8;

  logic [NumBanks-1:0] bank_busy;

  for (genvar b = 0; b < NumBanks; b++) begin : g_bank
    axi_mem_rw_bank_arb_slice #(
      .AddrWidth      (AddrWidth),
      .MemDataWidth   (MemDataWidth),
      .MaxOutstanding (MaxOutstanding)
    ) u_slice (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .rd_req_i     (rd_req_i[b]),
      .wr_req_i     (wr_req_i[b]),
      .rd_gnt_o     (rd_gnt_o[b]),
      .wr_gnt_o     (wr_gnt_o[b]),
      .rd_addr_i    (rd_addr_i[b*AddrWidth +: AddrWidth]),
      .wr_addr_i    (wr_addr_i[b*AddrWidth +: AddrWidth]),
      .rd_wdata_i   (rd_wdata_i[b*MemDataWidth +: MemDataWidth]),
      .wr_wdata_i   (wr_wdata_i[b*MemDataWidth +: MemDataWidth]),
      .rd_strb_i    (rd_strb_i[b*StrbWidth +: StrbWidth]),
      .wr_strb_i    (wr_strb_i[b*StrbWidth +: StrbWidth]),
      .rd_atop_i    (rd_atop_i[b*AtopWidth +: AtopWidth]),
      .wr_atop_i    (wr_atop_i[b*AtopWidth +: AtopWidth]),
      .rd_we_i      (rd_we_i[b]),
      .wr_we_i      (wr_we_i[b]),
      .rd_rvalid_o  (rd_rvalid_o[b]),
      .wr_rvalid_o  (wr_rvalid_o[b]),
      .rd_rdata_o   (rd_rdata_o[b*MemDataWidth +: MemDataWidth]),
      .wr_rdata_o   (wr_rdata_o[b*MemDataWidth +: MemDataWidth]),
      .mem_req_o    (mem_req_o[b]),
      .mem_gnt_i    (mem_gnt_i[b]),
      .mem_addr_o   (mem_addr_o[b*AddrWidth +: AddrWidth]),
      .mem_wdata_o  (mem_wdata_o[b*MemDataWidth +: MemDataWidth]),
      .mem_strb_o   (mem_strb_o[b*StrbWidth +: StrbWidth]),
      .mem_atop_o   (mem_atop_o[b*AtopWidth +: AtopWidth]),
      .mem_we_o     (mem_we_o[b]),
      .mem_rvalid_i (mem_rvalid_i[b]),
      .mem_rdata_i  (mem_rdata_i[b*MemDataWidth +: MemDataWidth]),
      .busy_o       (bank_busy[b])
    );
  end

  assign busy_o = |bank_busy;

endmodule
